// File: rtl/register_file_8x16.sv
// Eight-entry, 16-bit general-purpose register file: one synchronous write port,
// two independent combinational read ports, active-low write and output enables.
module register_file_8x16 #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  oe,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [ADDR_WIDTH-1:0] read_address0,
  input  logic [ADDR_WIDTH-1:0] read_address1,
  input  logic [DATA_WIDTH-1:0] write,
  output logic [DATA_WIDTH-1:0] read0,
  output logic [DATA_WIDTH-1:0] read1
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0]      write_select;
  logic [DATA_WIDTH-1:0] reg_value [DEPTH];

  // Each register owns its flops, so only the decoded entry can change on a write.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] data_reg;

      assign write_select[gi] = !we && (write_address == ADDR_WIDTH'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= '0;
        end else if (write_select[gi]) begin
          data_reg <= write;
        end
      end

      assign reg_value[gi] = data_reg;
    end
  endgenerate

  // No write bypass: reads see storage only, and oe high forces zero rather than high-Z.
  assign read0 = oe ? '0 : reg_value[read_address0];
  assign read1 = oe ? '0 : reg_value[read_address1];

endmodule

// File: tb/tb_register_file_8x16.sv
// Directed bench for register_file_8x16: one task per scenario, inline checks,
// one summary line at the end.
module tb_register_file_8x16;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic        oe;
  logic [2:0]  write_address;
  logic [2:0]  read_address0;
  logic [2:0]  read_address1;
  logic [15:0] write;
  logic [15:0] read0;
  logic [15:0] read1;

  int checks = 0;
  int errors = 0;

  register_file_8x16 dut (
    .clk           (clk),
    .rst           (rst),
    .we            (we),
    .oe            (oe),
    .write_address (write_address),
    .read_address0 (read_address0),
    .read_address1 (read_address1),
    .write         (write),
    .read0         (read0),
    .read1         (read1)
  );

  always #5 clk = ~clk;

  task automatic do_write(input logic [2:0] addr, input logic [15:0] data);
    write_address = addr;
    write         = data;
    we            = 1'b0;
    @(posedge clk);
    #1;
    we = 1'b1;
    $display("write R%0d <= %h", addr, data);
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b1; oe = 1'b0;
    write_address = 3'd0; write = 16'h0000;
    read_address0 = 3'd0; read_address1 = 3'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      read_address0 = 3'(a);
      read_address1 = 3'(7 - a);
      #1;
      checks++;
      if (read0 !== 16'h0000) begin
        errors++;
        $display("FAIL reset_read0 addr=%0d got %h expected 0000", a, read0);
      end
      checks++;
      if (read1 !== 16'h0000) begin
        errors++;
        $display("FAIL reset_read1 addr=%0d got %h expected 0000", 7 - a, read1);
      end
      $display("reset read addr %0d/%0d -> %h %h", a, 7 - a, read0, read1);
    end
  endtask

  task automatic test_write_oe_disabled();
    oe = 1'b1; read_address0 = 3'd3; read_address1 = 3'd5;
    do_write(3'd3, 16'hF000);
    checks++;
    if (read0 !== 16'h0000 || read1 !== 16'h0000) begin
      errors++;
      $display("FAIL oe_disabled got %h %h expected 0000 0000", read0, read1);
    end
    $display("oe=1 after write R3 -> %h %h", read0, read1);
    oe = 1'b0; we = 1'b1; write_address = 3'd5; write = 16'h0F00;
    @(posedge clk);
    #1;
    checks++;
    if (read0 !== 16'hF000) begin
      errors++;
      $display("FAIL oe_enabled_r3 got %h expected f000", read0);
    end
    checks++;
    if (read1 !== 16'h0000) begin
      errors++;
      $display("FAIL we_high_r5 got %h expected 0000", read1);
    end
    $display("oe=0 we=1 -> R3=%h R5=%h", read0, read1);
  endtask

  task automatic test_write_all();
    logic [15:0] exp0;
    logic [15:0] exp1;
    oe = 1'b0;
    for (int i = 0; i < 8; i++) do_write(3'(i), 16'(i * 16'h1111));
    for (int i = 0; i < 8; i++) begin
      read_address0 = 3'(i);
      read_address1 = 3'(7 - i);
      exp0 = 16'(i * 16'h1111);
      exp1 = 16'((7 - i) * 16'h1111);
      #1;
      checks++;
      if (read0 !== exp0) begin
        errors++;
        $display("FAIL sweep_read0 addr=%0d got %h expected %h", i, read0, exp0);
      end
      checks++;
      if (read1 !== exp1) begin
        errors++;
        $display("FAIL sweep_read1 addr=%0d got %h expected %h", 7 - i, read1, exp1);
      end
      $display("sweep %0d/%0d -> %h %h", i, 7 - i, read0, read1);
    end
  endtask

  task automatic test_read_during_write();
    oe = 1'b0;
    do_write(3'd2, 16'hAAAA);
    read_address0 = 3'd2;
    write_address = 3'd2; write = 16'h5555; we = 1'b0;
    #1;
    checks++;
    if (read0 !== 16'hAAAA) begin
      errors++;
      $display("FAIL rdw_before got %h expected aaaa", read0);
    end
    @(posedge clk);
    #1;
    we = 1'b1;
    checks++;
    if (read0 !== 16'h5555) begin
      errors++;
      $display("FAIL rdw_after got %h expected 5555", read0);
    end
    $display("read-during-write R2 -> %h", read0);
  endtask

  task automatic test_reset_priority();
    oe = 1'b0;
    read_address0 = 3'd4; read_address1 = 3'd1;
    #1;
    checks++;
    if (read0 !== 16'h4444) begin
      errors++;
      $display("FAIL prio_pre got %h expected 4444", read0);
    end
    rst = 1'b1; we = 1'b0; write_address = 3'd4; write = 16'hBEEF;
    @(posedge clk);
    #1;
    rst = 1'b0; we = 1'b1;
    checks++;
    if (read0 !== 16'h0000) begin
      errors++;
      $display("FAIL prio_r4 got %h expected 0000", read0);
    end
    checks++;
    if (read1 !== 16'h0000) begin
      errors++;
      $display("FAIL prio_r1 got %h expected 0000", read1);
    end
    $display("reset+write R4 -> R4=%h R1=%h", read0, read1);
  endtask

  task automatic test_dual_port_same_address();
    oe = 1'b0;
    do_write(3'd7, 16'h1234);
    read_address0 = 3'd7; read_address1 = 3'd7;
    #1;
    checks++;
    if (read0 !== 16'h1234 || read1 !== 16'h1234) begin
      errors++;
      $display("FAIL dual_same got %h %h expected 1234 1234", read0, read1);
    end
    oe = 1'b1;
    #1;
    checks++;
    if (read0 !== 16'h0000 || read1 !== 16'h0000) begin
      errors++;
      $display("FAIL dual_oe_off got %h %h expected 0000 0000", read0, read1);
    end
    oe = 1'b0;
    #1;
    checks++;
    if (read0 !== 16'h1234 || read1 !== 16'h1234) begin
      errors++;
      $display("FAIL dual_oe_on got %h %h expected 1234 1234", read0, read1);
    end
    $display("dual port R7 -> %h %h", read0, read1);
  endtask

  initial begin
    test_reset();
    test_write_oe_disabled();
    test_write_all();
    test_read_during_write();
    test_reset_priority();
    test_dual_port_same_address();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
